wb_stage: RTL and testbench

//  Write-back stage of the 16-bit RISC pipeline: MEM/WB pipeline register, write-back data mux
//  and return sequencer. Drives the register-file write side consumed by decode (Reg_data, RW_In_addr,
//  RW_Sig_in), reassembles the 32-bit return PC from two stacked 16-bit pops (RET/RTI) and restores CCR.

---
 rtl/wb_stage.sv | 156 +++++++++++++++
 tb/tb_wb_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back data mux, RET/RTI return sequencer.
// Latency 1 cycle from m_* to all outputs; stall freezes everything and suppresses pulses.
module wb_stage #(
    parameter int width = 16,
    parameter int PC_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               m_valid,
    input  logic               m_RegWR,
    input  logic               m_mem_to_Reg,
    input  logic               m_portR,
    input  logic               m_pop_pc1,
    input  logic               m_pop_pc2,
    input  logic               m_pop_ccr,
    input  logic [2:0]         m_rdst,
    input  logic [width-1:0]   m_alu_result,
    input  logic [width-1:0]   m_mem_data,
    input  logic [width-1:0]   in_port,
    output logic [width-1:0]   Reg_data,
    output logic [2:0]         RW_In_addr,
    output logic               RW_Sig_in,
    output logic               fwd_en,
    output logic [2:0]         fwd_addr,
    output logic [width-1:0]   fwd_data,
    output logic [PC_W-1:0]    pc_ret,
    output logic               pc_ret_valid,
    output logic [2:0]         ccr_restore,
    output logic               ccr_restore_valid,
    output logic               seq_err
);

    typedef enum logic {IDLE = 1'b0, HI = 1'b1} state_t;

    logic               cap_valid;
    logic               adv;
    logic [width-1:0]   wdata_d;

    logic               valid_q;
    logic               regwr_q;
    logic [2:0]         rdst_q;
    logic [width-1:0]   wdata_q;

    state_t             state_q, state_d;
    logic [width-1:0]   hi_half_q, hi_half_d;
    logic [PC_W-1:0]    pc_ret_q, pc_ret_d;
    logic               pc_vld_q, pc_vld_d;
    logic [2:0]         ccr_q, ccr_d;
    logic               ccr_vld_q, ccr_vld_d;
    logic               err_q, err_d;

    assign cap_valid = m_valid & ~flush;
    assign adv       = cap_valid & ~stall;

    always_comb begin
        if (m_portR)
            wdata_d = in_port;
        else if (m_mem_to_Reg)
            wdata_d = m_mem_data;
        else
            wdata_d = m_alu_result;
    end

    // Invalid or flushed entries are captured as an all-zero bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
            rdst_q  <= '0;
            wdata_q <= '0;
        end else if (!stall) begin
            valid_q <= cap_valid;
            regwr_q <= cap_valid & m_RegWR;
            rdst_q  <= cap_valid ? m_rdst : 3'd0;
            wdata_q <= cap_valid ? wdata_d : '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_half_d = hi_half_q;
        pc_ret_d  = pc_ret_q;
        pc_vld_d  = 1'b0;
        ccr_d     = ccr_q;
        ccr_vld_d = 1'b0;
        err_d     = err_q;
        if (adv) begin
            if (m_pop_pc1 && m_pop_pc2) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (m_pop_pc1) begin
                            hi_half_d = m_mem_data;
                            state_d   = HI;
                        end else if (m_pop_pc2) begin
                            err_d = 1'b1;
                        end
                    end
                    HI: begin
                        if (m_pop_pc2) begin
                            pc_ret_d = {hi_half_q, m_mem_data};
                            pc_vld_d = 1'b1;
                            state_d  = IDLE;
                        end else if (m_pop_pc1) begin
                            err_d     = 1'b1;
                            hi_half_d = m_mem_data;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            if (m_pop_ccr) begin
                ccr_d     = m_mem_data[2:0];
                ccr_vld_d = 1'b1;
            end
        end
    end

    // Pulses are rebuilt every cycle from the next-state logic, so a stall forces them low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            hi_half_q <= '0;
            pc_ret_q  <= '0;
            pc_vld_q  <= 1'b0;
            ccr_q     <= '0;
            ccr_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_half_q <= hi_half_d;
            pc_ret_q  <= pc_ret_d;
            pc_vld_q  <= pc_vld_d;
            ccr_q     <= ccr_d;
            ccr_vld_q <= ccr_vld_d;
            err_q     <= err_d;
        end
    end

    assign RW_Sig_in         = valid_q & regwr_q;
    assign RW_In_addr        = rdst_q;
    assign Reg_data          = wdata_q;
    assign fwd_en            = RW_Sig_in;
    assign fwd_addr          = RW_In_addr;
    assign fwd_data          = Reg_data;
    assign pc_ret            = pc_ret_q;
    assign pc_ret_valid      = pc_vld_q;
    assign ccr_restore       = ccr_q;
    assign ccr_restore_valid = ccr_vld_q;
    assign seq_err           = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: expected outputs queued per driven cycle, popped after the edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic        m_valid = 1'b0, m_RegWR = 1'b0, m_mem_to_Reg = 1'b0, m_portR = 1'b0;
    logic        m_pop_pc1 = 1'b0, m_pop_pc2 = 1'b0, m_pop_ccr = 1'b0;
    logic [2:0]  m_rdst = '0;
    logic [15:0] m_alu_result = '0, m_mem_data = '0, in_port = '0;
    logic [15:0] Reg_data, fwd_data;
    logic [2:0]  RW_In_addr, fwd_addr, ccr_restore;
    logic        RW_Sig_in, fwd_en, pc_ret_valid, ccr_restore_valid, seq_err;
    logic [31:0] pc_ret;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        pcv;
        logic [31:0] pc;
        logic        ccrv;
        logic [2:0]  ccr;
        logic        err;
    } exp_t;

    exp_t e;
    exp_t sb[$];

    wb_stage #(.width(16), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_RegWR(m_RegWR), .m_mem_to_Reg(m_mem_to_Reg), .m_portR(m_portR),
        .m_pop_pc1(m_pop_pc1), .m_pop_pc2(m_pop_pc2), .m_pop_ccr(m_pop_ccr),
        .m_rdst(m_rdst), .m_alu_result(m_alu_result), .m_mem_data(m_mem_data), .in_port(in_port),
        .Reg_data(Reg_data), .RW_In_addr(RW_In_addr), .RW_Sig_in(RW_Sig_in),
        .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .pc_ret(pc_ret), .pc_ret_valid(pc_ret_valid),
        .ccr_restore(ccr_restore), .ccr_restore_valid(ccr_restore_valid), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare(input exp_t x);
        chk("RW_Sig_in", {31'd0, RW_Sig_in}, {31'd0, x.wr});
        chk("RW_In_addr", {29'd0, RW_In_addr}, {29'd0, x.addr});
        chk("Reg_data", {16'd0, Reg_data}, {16'd0, x.data});
        chk("fwd_en", {31'd0, fwd_en}, {31'd0, x.wr});
        chk("fwd_addr", {29'd0, fwd_addr}, {29'd0, x.addr});
        chk("fwd_data", {16'd0, fwd_data}, {16'd0, x.data});
        chk("pc_ret_valid", {31'd0, pc_ret_valid}, {31'd0, x.pcv});
        chk("pc_ret", pc_ret, x.pc);
        chk("ccr_valid", {31'd0, ccr_restore_valid}, {31'd0, x.ccrv});
        chk("ccr_restore", {29'd0, ccr_restore}, {29'd0, x.ccr});
        chk("seq_err", {31'd0, seq_err}, {31'd0, x.err});
    endtask

    task automatic drive(input logic v, input logic wr, input logic m2r, input logic pr,
                         input logic p1, input logic p2, input logic pc,
                         input logic [2:0] rd, input logic [15:0] alu,
                         input logic [15:0] mem, input logic [15:0] inp);
        m_valid = v; m_RegWR = wr; m_mem_to_Reg = m2r; m_portR = pr;
        m_pop_pc1 = p1; m_pop_pc2 = p2; m_pop_ccr = pc;
        m_rdst = rd; m_alu_result = alu; m_mem_data = mem; in_port = inp;
    endtask

    task automatic bubble();
        drive(0, 0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0, 16'h0);
    endtask

    // Queue the expectation for the entry currently driven, clock it, then pop and compare.
    task automatic step(input logic wr, input logic [2:0] a, input logic [15:0] d,
                        input logic pv, input logic cv);
        exp_t got;
        e.wr = wr; e.addr = a; e.data = d; e.pcv = pv; e.ccrv = cv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard observed=empty expected=entry");
        end else begin
            got = sb.pop_front();
            compare(got);
        end
    endtask

    initial begin
        e = '{wr: 1'b0, addr: 3'd0, data: 16'h0, pcv: 1'b0, pc: 32'h0, ccrv: 1'b0, ccr: 3'd0, err: 1'b0};
        repeat (2) @(posedge clk);
        #1;
        compare(e);
        rst = 1'b1;

        // ALU write and mux priority
        drive(1, 1, 0, 0, 0, 0, 0, 3'd5, 16'h1234, 16'h0, 16'h0);
        step(1, 3'd5, 16'h1234, 0, 0);
        drive(1, 1, 1, 1, 0, 0, 0, 3'd2, 16'h0F0F, 16'h5555, 16'hAAAA);
        step(1, 3'd2, 16'hAAAA, 0, 0);
        drive(1, 1, 1, 0, 0, 0, 0, 3'd3, 16'h7777, 16'h5555, 16'hAAAA);
        step(1, 3'd3, 16'h5555, 0, 0);

        // RET with a two-bubble gap
        drive(1, 0, 0, 0, 1, 0, 0, 3'd0, 16'h0, 16'h0001, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);
        bubble(); step(0, 3'd0, 16'h0, 0, 0);
        bubble(); step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'h0200, 16'h0);
        e.pc = 32'h0001_0200;
        step(0, 3'd0, 16'h0, 1, 0);
        bubble(); step(0, 3'd0, 16'h0, 0, 0);

        // RTI: CCR pop, PC pops (with a register write), CCR+PC2 in one entry
        drive(1, 0, 0, 0, 0, 0, 1, 3'd0, 16'h0, 16'h0005, 16'h0);
        e.ccr = 3'b101;
        step(0, 3'd0, 16'h0, 0, 1);
        drive(1, 1, 1, 0, 1, 0, 0, 3'd7, 16'h0, 16'h00AB, 16'h0);
        step(1, 3'd7, 16'h00AB, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 1, 3'd0, 16'h0, 16'hCDE6, 16'h0);
        e.pc = 32'h00AB_CDE6; e.ccr = 3'b110;
        step(0, 3'd0, 16'h0, 1, 1);

        // Stall mid-HI, then flushed write
        drive(1, 1, 0, 0, 1, 0, 0, 3'd4, 16'h4444, 16'h1111, 16'h0);
        step(1, 3'd4, 16'h4444, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'h2222, 16'h0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 3'd4, 16'h4444, 0, 0);
        stall = 1'b0;
        e.pc = 32'h1111_2222;
        step(0, 3'd0, 16'h0, 1, 0);
        drive(1, 1, 0, 0, 1, 0, 0, 3'd6, 16'h6666, 16'h3333, 16'h0);
        flush = 1'b1;
        step(0, 3'd0, 16'h0, 0, 0);
        flush = 1'b0;

        // Sequencing errors: PC2 in IDLE is an error, proving the flushed PC1 was ignored
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'h0BAD, 16'h0);
        e.err = 1'b1;
        step(0, 3'd0, 16'h0, 0, 0);
        bubble(); step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0, 3'd0, 16'h0, 16'hAAAA, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 1, 0, 0, 3'd0, 16'h0, 16'hBBBB, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'hCCCC, 16'h0);
        e.pc = 32'hBBBB_CCCC;
        step(0, 3'd0, 16'h0, 1, 0);
        drive(1, 0, 0, 0, 1, 0, 0, 3'd0, 16'h0, 16'h0001, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 1, 1, 0, 3'd0, 16'h0, 16'h0002, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'h0003, 16'h0);
        step(0, 3'd0, 16'h0, 0, 0);

        // Reset while in HI
        drive(1, 1, 0, 0, 1, 0, 0, 3'd1, 16'h0101, 16'h9999, 16'h0);
        step(1, 3'd1, 16'h0101, 0, 0);
        rst = 1'b0;
        #1;
        e = '{wr: 1'b0, addr: 3'd0, data: 16'h0, pcv: 1'b0, pc: 32'h0, ccrv: 1'b0, ccr: 3'd0, err: 1'b0};
        compare(e);
        @(posedge clk);
        #1;
        compare(e);
        rst = 1'b1;
        drive(1, 0, 0, 0, 0, 1, 0, 3'd0, 16'h0, 16'h0001, 16'h0);
        e.err = 1'b1;
        step(0, 3'd0, 16'h0, 0, 0);
        bubble(); step(0, 3'd0, 16'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
